// File: rtl/munoc_axi4l_slave_request_engine.sv
// Slave-side AXI4-Lite request engine: replays one decoded NoC request at a
// time onto a local AXI4-Lite slave and returns a single tagged response.
// An optional response timeout turns a hung B/R channel into DECERR and
// quietly drains the late response when it eventually shows up.
module munoc_axi4l_slave_request_engine #(
  parameter int BW_PLATFORM_ADDR = 32,
  parameter int BW_NODE_DATA     = 32,
  parameter int BW_TAG           = 4,
  parameter int TIMEOUT_CYCLES   = 0
) (
  input  logic                        clk,
  input  logic                        rstnn,
  input  logic                        comm_disable,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_write,
  input  logic [BW_PLATFORM_ADDR-1:0] req_addr,
  input  logic [BW_NODE_DATA-1:0]     req_wdata,
  input  logic [BW_NODE_DATA/8-1:0]   req_wstrb,
  input  logic [BW_TAG-1:0]           req_tag,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic                        rsp_write,
  output logic [BW_NODE_DATA-1:0]     rsp_data,
  output logic [1:0]                  rsp_resp,
  output logic [BW_TAG-1:0]           rsp_tag,
  output logic [BW_PLATFORM_ADDR-1:0] tx4lawaddr,
  output logic                        tx4lawvalid,
  input  logic                        tx4lawready,
  output logic [BW_NODE_DATA-1:0]     tx4lwdata,
  output logic [BW_NODE_DATA/8-1:0]   tx4lwstrb,
  output logic                        tx4lwvalid,
  input  logic                        tx4lwready,
  input  logic [1:0]                  tx4lbresp,
  input  logic                        tx4lbvalid,
  output logic                        tx4lbready,
  output logic [BW_PLATFORM_ADDR-1:0] tx4laraddr,
  output logic                        tx4larvalid,
  input  logic                        tx4larready,
  input  logic [BW_NODE_DATA-1:0]     tx4lrdata,
  input  logic [1:0]                  tx4lrresp,
  input  logic                        tx4lrvalid,
  output logic                        tx4lrready,
  output logic                        busy
);

  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1) + 1;
  // Timer value seen in the last permitted wait cycle.
  localparam logic [TIMER_W-1:0] TIMER_LAST =
    (TIMEOUT_CYCLES > 0) ? TIMER_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_RESP,
    ST_RESPOND
  } state_t;

  state_t                      state_reg, state_next;
  logic                        req_ready_reg, req_ready_next;
  logic                        awvalid_reg, awvalid_next;
  logic                        wvalid_reg, wvalid_next;
  logic                        bready_reg, bready_next;
  logic                        arvalid_reg, arvalid_next;
  logic                        rready_reg, rready_next;
  logic [BW_PLATFORM_ADDR-1:0] awaddr_reg, awaddr_next;
  logic [BW_PLATFORM_ADDR-1:0] araddr_reg, araddr_next;
  logic [BW_NODE_DATA-1:0]     wdata_reg, wdata_next;
  logic [BW_NODE_DATA/8-1:0]   wstrb_reg, wstrb_next;
  logic                        rsp_valid_reg, rsp_valid_next;
  logic                        rsp_write_reg, rsp_write_next;
  logic [BW_NODE_DATA-1:0]     rsp_data_reg, rsp_data_next;
  logic [1:0]                  rsp_resp_reg, rsp_resp_next;
  logic [BW_TAG-1:0]           rsp_tag_reg, rsp_tag_next;
  logic                        drain_b_reg, drain_b_next;
  logic                        drain_r_reg, drain_r_next;
  logic [TIMER_W-1:0]          timer_reg, timer_next;
  logic                        busy_reg, busy_next;
  logic                        timeout_hit;
  logic                        aw_done;
  logic                        w_done;

  assign timeout_hit = (TIMEOUT_CYCLES > 0) && (timer_reg >= TIMER_LAST);
  // A channel counts as done once its valid is down or is handshaking now.
  assign aw_done     = !awvalid_reg || tx4lawready;
  assign w_done      = !wvalid_reg  || tx4lwready;

  // State and registered-output update; reset aborts any transaction silently.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state_reg     <= ST_IDLE;
      req_ready_reg <= 1'b0;
      awvalid_reg   <= 1'b0;
      wvalid_reg    <= 1'b0;
      bready_reg    <= 1'b0;
      arvalid_reg   <= 1'b0;
      rready_reg    <= 1'b0;
      awaddr_reg    <= '0;
      araddr_reg    <= '0;
      wdata_reg     <= '0;
      wstrb_reg     <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_write_reg <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_resp_reg  <= '0;
      rsp_tag_reg   <= '0;
      drain_b_reg   <= 1'b0;
      drain_r_reg   <= 1'b0;
      timer_reg     <= '0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      req_ready_reg <= req_ready_next;
      awvalid_reg   <= awvalid_next;
      wvalid_reg    <= wvalid_next;
      bready_reg    <= bready_next;
      arvalid_reg   <= arvalid_next;
      rready_reg    <= rready_next;
      awaddr_reg    <= awaddr_next;
      araddr_reg    <= araddr_next;
      wdata_reg     <= wdata_next;
      wstrb_reg     <= wstrb_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_write_reg <= rsp_write_next;
      rsp_data_reg  <= rsp_data_next;
      rsp_resp_reg  <= rsp_resp_next;
      rsp_tag_reg   <= rsp_tag_next;
      drain_b_reg   <= drain_b_next;
      drain_r_reg   <= drain_r_next;
      timer_reg     <= timer_next;
      busy_reg      <= busy_next;
    end
  end

  // Next-state and next-output logic for the single-outstanding transaction.
  always_comb begin
    state_next     = state_reg;
    awvalid_next   = awvalid_reg;
    wvalid_next    = wvalid_reg;
    arvalid_next   = arvalid_reg;
    awaddr_next    = awaddr_reg;
    araddr_next    = araddr_reg;
    wdata_next     = wdata_reg;
    wstrb_next     = wstrb_reg;
    rsp_valid_next = rsp_valid_reg;
    rsp_write_next = rsp_write_reg;
    rsp_data_next  = rsp_data_reg;
    rsp_resp_next  = rsp_resp_reg;
    rsp_tag_next   = rsp_tag_reg;
    drain_b_next   = drain_b_reg;
    drain_r_next   = drain_r_reg;
    timer_next     = timer_reg;

    // A late response after a timeout is swallowed here, whatever the state.
    if (drain_b_reg && tx4lbvalid && bready_reg) drain_b_next = 1'b0;
    if (drain_r_reg && tx4lrvalid && rready_reg) drain_r_next = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (req_valid && req_ready_reg) begin
          rsp_write_next = req_write;
          rsp_tag_next   = req_tag;
          if (req_write) begin
            awaddr_next  = req_addr;
            wdata_next   = req_wdata;
            wstrb_next   = req_wstrb;
            awvalid_next = 1'b1;
            wvalid_next  = 1'b1;
            state_next   = ST_WR_REQ;
          end else begin
            araddr_next  = req_addr;
            arvalid_next = 1'b1;
            state_next   = ST_RD_REQ;
          end
        end
      end
      ST_WR_REQ: begin
        if (tx4lawready) awvalid_next = 1'b0;
        if (tx4lwready)  wvalid_next  = 1'b0;
        if (aw_done && w_done) begin
          awvalid_next = 1'b0;
          wvalid_next  = 1'b0;
          timer_next   = '0;
          state_next   = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        // A real B in the expiring cycle takes priority over the timeout.
        if (tx4lbvalid && bready_reg) begin
          rsp_data_next  = '0;
          rsp_resp_next  = tx4lbresp;
          rsp_valid_next = 1'b1;
          state_next     = ST_RESPOND;
        end else if (timeout_hit) begin
          rsp_data_next  = '0;
          rsp_resp_next  = 2'b11;
          rsp_valid_next = 1'b1;
          drain_b_next   = 1'b1;
          state_next     = ST_RESPOND;
        end else if (timer_reg != {TIMER_W{1'b1}}) begin
          timer_next = timer_reg + TIMER_W'(1);
        end
      end
      ST_RD_REQ: begin
        if (tx4larready) begin
          arvalid_next = 1'b0;
          timer_next   = '0;
          state_next   = ST_RD_RESP;
        end
      end
      ST_RD_RESP: begin
        if (tx4lrvalid && rready_reg) begin
          rsp_data_next  = tx4lrdata;
          rsp_resp_next  = tx4lrresp;
          rsp_valid_next = 1'b1;
          state_next     = ST_RESPOND;
        end else if (timeout_hit) begin
          rsp_data_next  = '0;
          rsp_resp_next  = 2'b11;
          rsp_valid_next = 1'b1;
          drain_r_next   = 1'b1;
          state_next     = ST_RESPOND;
        end else if (timer_reg != {TIMER_W{1'b1}}) begin
          timer_next = timer_reg + TIMER_W'(1);
        end
      end
      ST_RESPOND: begin
        if (rsp_ready) begin
          rsp_valid_next = 1'b0;
          state_next     = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Readies and status are all derived from next state so they stay registered.
    bready_next    = (state_next == ST_WR_RESP) || drain_b_next;
    rready_next    = (state_next == ST_RD_RESP) || drain_r_next;
    req_ready_next = (state_next == ST_IDLE) && !comm_disable &&
                     !drain_b_next && !drain_r_next;
    busy_next      = (state_next != ST_IDLE) || drain_b_next || drain_r_next;
  end

  assign req_ready   = req_ready_reg;
  assign tx4lawaddr  = awaddr_reg;
  assign tx4lawvalid = awvalid_reg;
  assign tx4lwdata   = wdata_reg;
  assign tx4lwstrb   = wstrb_reg;
  assign tx4lwvalid  = wvalid_reg;
  assign tx4lbready  = bready_reg;
  assign tx4laraddr  = araddr_reg;
  assign tx4larvalid = arvalid_reg;
  assign tx4lrready  = rready_reg;
  assign rsp_valid   = rsp_valid_reg;
  assign rsp_write   = rsp_write_reg;
  assign rsp_data    = rsp_data_reg;
  assign rsp_resp    = rsp_resp_reg;
  assign rsp_tag     = rsp_tag_reg;
  assign busy        = busy_reg;

endmodule

// File: tb/tb_munoc_axi4l_slave_request_engine.sv
// Bench for the AXI4-Lite slave request engine: a delay-configurable AXI
// slave, a NoC-side driver, and an abstract response/latency model.
`timescale 1ns/1ps
module tb_munoc_axi4l_slave_request_engine;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TGW = 4;
  localparam int TO  = 8;

  logic            clk = 1'b0;
  logic            rstnn = 1'b0;
  logic            comm_disable = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic            req_write = 1'b0;
  logic [AW-1:0]   req_addr = '0;
  logic [DW-1:0]   req_wdata = '0;
  logic [DW/8-1:0] req_wstrb = '0;
  logic [TGW-1:0]  req_tag = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic            rsp_write;
  logic [DW-1:0]   rsp_data;
  logic [1:0]      rsp_resp;
  logic [TGW-1:0]  rsp_tag;
  logic [AW-1:0]   tx4lawaddr;
  logic            tx4lawvalid;
  logic            tx4lawready = 1'b0;
  logic [DW-1:0]   tx4lwdata;
  logic [DW/8-1:0] tx4lwstrb;
  logic            tx4lwvalid;
  logic            tx4lwready = 1'b0;
  logic [1:0]      tx4lbresp = '0;
  logic            tx4lbvalid = 1'b0;
  logic            tx4lbready;
  logic [AW-1:0]   tx4laraddr;
  logic            tx4larvalid;
  logic            tx4larready = 1'b0;
  logic [DW-1:0]   tx4lrdata = '0;
  logic [1:0]      tx4lrresp = '0;
  logic            tx4lrvalid = 1'b0;
  logic            tx4lrready;
  logic            busy;

  int checks = 0;
  int errors = 0;

  // Slave configuration and observation
  int aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
  logic [1:0]      sl_bresp = '0, sl_rresp = '0;
  logic [DW-1:0]   sl_rdata = '0;
  int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0, aw_high = 0, w_high = 0;
  logic [AW-1:0]   sl_awaddr = '0, sl_araddr = '0;
  logic [DW-1:0]   sl_wdata = '0;
  logic [DW/8-1:0] sl_wstrb = '0;

  typedef struct packed {
    logic           write;
    logic [DW-1:0]  data;
    logic [1:0]     resp;
    logic [TGW-1:0] tag;
  } rsp_t;

  munoc_axi4l_slave_request_engine #(
    .BW_PLATFORM_ADDR(AW), .BW_NODE_DATA(DW), .BW_TAG(TGW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rstnn(rstnn), .comm_disable(comm_disable),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_data(rsp_data), .rsp_resp(rsp_resp), .rsp_tag(rsp_tag),
    .tx4lawaddr(tx4lawaddr), .tx4lawvalid(tx4lawvalid), .tx4lawready(tx4lawready),
    .tx4lwdata(tx4lwdata), .tx4lwstrb(tx4lwstrb), .tx4lwvalid(tx4lwvalid), .tx4lwready(tx4lwready),
    .tx4lbresp(tx4lbresp), .tx4lbvalid(tx4lbvalid), .tx4lbready(tx4lbready),
    .tx4laraddr(tx4laraddr), .tx4larvalid(tx4larvalid), .tx4larready(tx4larready),
    .tx4lrdata(tx4lrdata), .tx4lrresp(tx4lrresp), .tx4lrvalid(tx4lrvalid), .tx4lrready(tx4lrready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Expected response: slave answer if it comes within the window, else DECERR.
  function automatic rsp_t model_rsp(input logic w, input logic [TGW-1:0] t, input int rd,
                                     input logic [1:0] br, input logic [1:0] rr,
                                     input logic [DW-1:0] rdat);
    rsp_t e;
    e.write = w;
    e.tag   = t;
    if (rd >= TO)  begin e.data = '0;   e.resp = 2'b11; end
    else if (w)    begin e.data = '0;   e.resp = br;    end
    else           begin e.data = rdat; e.resp = rr;    end
    return e;
  endfunction

  // Expected cycles from the first cycle after request acceptance until rsp_valid, plus 1.
  function automatic int model_lat(input logic w, input int awd, input int wd,
                                   input int ard, input int rd);
    int issue;
    issue = w ? ((awd > wd) ? awd : wd) : ard;
    return 3 + issue + ((rd >= TO) ? TO - 1 : rd);
  endfunction

  // Behavioural AXI4-Lite slave, stepped on the falling edge.
  initial begin
    int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    logic aw_got, w_got, b_owed, r_owed;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
    aw_got = 0; w_got = 0; b_owed = 0; r_owed = 0;
    forever begin
      @(negedge clk);
      if (!rstnn) begin
        tx4lawready = 0; tx4lwready = 0; tx4larready = 0;
        tx4lbvalid = 0; tx4lrvalid = 0;
        aw_got = 0; w_got = 0; b_owed = 0; r_owed = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
      end else begin
        if (b_owed) begin
          if (b_cnt >= b_delay) begin tx4lbvalid = 1; tx4lbresp = sl_bresp; end
          else b_cnt++;
        end else begin tx4lbvalid = 0; tx4lbresp = 0; end
        if (tx4lbvalid && tx4lbready) begin b_hs++; b_owed = 0; end

        if (r_owed) begin
          if (r_cnt >= r_delay) begin tx4lrvalid = 1; tx4lrdata = sl_rdata; tx4lrresp = sl_rresp; end
          else r_cnt++;
        end else begin tx4lrvalid = 0; tx4lrdata = 0; tx4lrresp = 0; end
        if (tx4lrvalid && tx4lrready) begin r_hs++; r_owed = 0; end

        if (tx4lawvalid) begin
          aw_high++;
          tx4lawready = (aw_cnt >= aw_delay);
          if (tx4lawready) begin aw_hs++; sl_awaddr = tx4lawaddr; aw_got = 1; aw_cnt = 0; end
          else aw_cnt++;
        end else begin tx4lawready = 0; aw_cnt = 0; end

        if (tx4lwvalid) begin
          w_high++;
          tx4lwready = (w_cnt >= w_delay);
          if (tx4lwready) begin w_hs++; sl_wdata = tx4lwdata; sl_wstrb = tx4lwstrb; w_got = 1; w_cnt = 0; end
          else w_cnt++;
        end else begin tx4lwready = 0; w_cnt = 0; end

        if (aw_got && w_got) begin b_owed = 1; b_cnt = 0; aw_got = 0; w_got = 0; end

        if (tx4larvalid) begin
          tx4larready = (ar_cnt >= ar_delay);
          if (tx4larready) begin ar_hs++; sl_araddr = tx4laraddr; r_owed = 1; r_cnt = 0; ar_cnt = 0; end
          else ar_cnt++;
        end else begin tx4larready = 0; ar_cnt = 0; end
      end
    end
  end

  // Present a request and return on the falling edge one cycle after acceptance.
  task automatic send_req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [DW/8-1:0] s, input logic [TGW-1:0] t);
    int k;
    @(negedge clk);
    req_valid = 1; req_write = w; req_addr = a; req_wdata = d; req_wstrb = s; req_tag = t;
    k = 0;
    while (!req_ready && k < 100) begin @(negedge clk); k++; end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL req_accept: req_ready=%0b after %0d cycles, required 1", req_ready, k);
    end
    @(negedge clk);
    req_valid = 0;
  endtask

  // Wait for a response, hold rsp_ready low for 'hold' cycles, then accept it.
  task automatic get_rsp(input int hold, output rsp_t got, output int lat, output logic stable);
    rsp_t first;
    lat = 1; stable = 1;
    while (!rsp_valid && lat < 300) begin @(negedge clk); lat++; end
    if (!rsp_valid) begin
      checks++; errors++;
      $display("FAIL rsp_wait: rsp_valid=0 after %0d cycles, required 1", lat);
    end
    first = {rsp_write, rsp_data, rsp_resp, rsp_tag};
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (!rsp_valid || ({rsp_write, rsp_data, rsp_resp, rsp_tag} != first)) stable = 0;
    end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    got = first;
  endtask

  task automatic test_reset();
    rstnn = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({req_ready, tx4lawvalid, tx4lwvalid, tx4larvalid, tx4lbready, tx4lrready, rsp_valid, busy} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 00000000",
               {req_ready, tx4lawvalid, tx4lwvalid, tx4larvalid, tx4lbready, tx4lrready, rsp_valid, busy});
    end
    checks++;
    if ({rsp_data, rsp_resp, rsp_tag, tx4lawaddr, tx4laraddr} !== '0) begin
      errors++; $display("FAIL reset_data: rsp/addr fields not 0");
    end
    rstnn = 1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL post_reset_ready: req_ready=%0b busy=%0b required 1 0", req_ready, busy);
    end
    $display("TXN reset done");
  endtask

  task automatic test_write_basic();
    rsp_t got, exp;
    int lat;
    logic st;
    aw_delay = 0; w_delay = 0; b_delay = 0; sl_bresp = 2'b00;
    aw_high = 0; w_high = 0;
    send_req(1, 32'h100, 32'hA5A5A5A5, 4'hF, 4'd3);
    checks++;
    if (tx4lawvalid !== 1'b1 || tx4lwvalid !== 1'b1) begin
      errors++; $display("FAIL wr_issue_cycle1: awvalid=%0b wvalid=%0b required 1 1", tx4lawvalid, tx4lwvalid);
    end
    get_rsp(0, got, lat, st);
    exp = model_rsp(1, 4'd3, 0, sl_bresp, sl_rresp, sl_rdata);
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL wr_basic_rsp: got %h required %h", got, exp);
    end
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL wr_basic_latency: got %0d required 3", lat); end
    checks++;
    if (sl_awaddr !== 32'h100 || sl_wdata !== 32'hA5A5A5A5 || sl_wstrb !== 4'hF) begin
      errors++; $display("FAIL wr_basic_slave: addr=%h data=%h strb=%h required 100 a5a5a5a5 f",
                         sl_awaddr, sl_wdata, sl_wstrb);
    end
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL wr_basic_next_ready: req_ready=%0b rsp_valid=%0b required 1 0", req_ready, rsp_valid);
    end
    $display("TXN write addr=00000100 tag=%0d resp=%0d lat=%0d", got.tag, got.resp, lat);
  endtask

  task automatic test_write_aw_delay();
    rsp_t got;
    int lat, b0;
    logic st;
    aw_delay = 4; w_delay = 0; b_delay = 0; sl_bresp = 2'b01;
    aw_high = 0; w_high = 0; b0 = b_hs;
    send_req(1, 32'h0000_0444, 32'hDEADBEEF, 4'h5, 4'd9);
    get_rsp(0, got, lat, st);
    repeat (3) @(negedge clk);
    checks++;
    if (aw_high !== 5 || w_high !== 1) begin
      errors++; $display("FAIL wr_awdelay_valid_cycles: aw=%0d w=%0d required 5 1", aw_high, w_high);
    end
    checks++;
    if (b_hs - b0 !== 1) begin errors++; $display("FAIL wr_awdelay_b_count: got %0d required 1", b_hs - b0); end
    checks++;
    if (got.resp !== 2'b01 || got.tag !== 4'd9 || lat !== model_lat(1, 4, 0, 0, 0)) begin
      errors++; $display("FAIL wr_awdelay_rsp: resp=%0d tag=%0d lat=%0d required 1 9 %0d",
                         got.resp, got.tag, lat, model_lat(1, 4, 0, 0, 0));
    end
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_awdelay_single_rsp: rsp_valid=%0b required 0", rsp_valid); end
    aw_delay = 0;
    $display("TXN write addr=00000444 tag=%0d resp=%0d lat=%0d", got.tag, got.resp, lat);
  endtask

  task automatic test_read_hold();
    rsp_t got, exp;
    int lat;
    logic st;
    ar_delay = 0; r_delay = 0; sl_rdata = 32'h12345678; sl_rresp = 2'b10;
    send_req(0, 32'h200, 32'h0, 4'h0, 4'd6);
    get_rsp(3, got, lat, st);
    exp = model_rsp(0, 4'd6, 0, sl_bresp, sl_rresp, sl_rdata);
    checks++;
    if (st !== 1'b1) begin errors++; $display("FAIL rd_hold_stable: stable=%0b required 1", st); end
    checks++;
    if (got !== exp) begin errors++; $display("FAIL rd_hold_rsp: got %h required %h", got, exp); end
    checks++;
    if (sl_araddr !== 32'h200) begin errors++; $display("FAIL rd_hold_araddr: got %h required 200", sl_araddr); end
    $display("TXN read addr=00000200 tag=%0d data=%h resp=%0d lat=%0d", got.tag, got.data, got.resp, lat);
  endtask

  task automatic test_timeout();
    rsp_t got, exp;
    int lat, r0, k;
    logic st, viol;
    // Late R: DECERR after the window, then the straggler is drained.
    ar_delay = 0; r_delay = 15; sl_rdata = 32'hCAFE0001; sl_rresp = 2'b00;
    r0 = r_hs;
    send_req(0, 32'h300, 32'h0, 4'h0, 4'd11);
    get_rsp(0, got, lat, st);
    exp = model_rsp(0, 4'd11, 15, sl_bresp, sl_rresp, sl_rdata);
    checks++;
    if (got !== exp || lat !== model_lat(0, 0, 0, 0, 15)) begin
      errors++; $display("FAIL timeout_rsp: got %h lat=%0d required %h lat=%0d",
                         got, lat, exp, model_lat(0, 0, 0, 0, 15));
    end
    viol = 0; k = 0;
    #1;
    while (r_hs == r0 && k < 40) begin
      if (busy !== 1'b1 || req_ready !== 1'b0 || rsp_valid !== 1'b0 || tx4lrready !== 1'b1) viol = 1;
      @(negedge clk); #1; k++;
    end
    checks++;
    if (viol || r_hs - r0 !== 1) begin
      errors++; $display("FAIL timeout_drain: viol=%0b r_count=%0d required 0 1", viol, r_hs - r0);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || req_ready !== 1'b1 || tx4lrready !== 1'b0) begin
      errors++; $display("FAIL timeout_drain_done: busy=%0b req_ready=%0b rready=%0b required 0 1 0",
                         busy, req_ready, tx4lrready);
    end
    $display("TXN read addr=00000300 tag=%0d resp=%0d lat=%0d (timeout)", got.tag, got.resp, lat);
    // R arriving in the final cycle of the window beats the timeout.
    r_delay = TO - 1; sl_rdata = 32'h0BADF00D; sl_rresp = 2'b01;
    send_req(0, 32'h304, 32'h0, 4'h0, 4'd12);
    get_rsp(0, got, lat, st);
    exp = model_rsp(0, 4'd12, TO - 1, sl_bresp, sl_rresp, sl_rdata);
    checks++;
    if (got !== exp || lat !== model_lat(0, 0, 0, 0, TO - 1)) begin
      errors++; $display("FAIL timeout_race: got %h lat=%0d required %h lat=%0d",
                         got, lat, exp, model_lat(0, 0, 0, 0, TO - 1));
    end
    checks++;
    if (busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL timeout_race_nodrain: busy=%0b req_ready=%0b required 0 1", busy, req_ready);
    end
    r_delay = 0;
    $display("TXN read addr=00000304 tag=%0d resp=%0d lat=%0d (edge)", got.tag, got.resp, lat);
  endtask

  task automatic test_comm_disable();
    rsp_t got, exp;
    int lat, aw0, ar0;
    logic st, viol;
    @(negedge clk);
    comm_disable = 1;
    repeat (2) @(negedge clk);
    aw0 = aw_hs; ar0 = ar_hs;
    req_valid = 1; req_write = 0; req_addr = 32'h500; req_tag = 4'd5;
    sl_rdata = 32'h55AA55AA; sl_rresp = 2'b00;
    viol = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (req_ready !== 1'b0 || tx4larvalid !== 1'b0 || tx4lawvalid !== 1'b0 || busy !== 1'b0) viol = 1;
    end
    checks++;
    if (viol || aw_hs != aw0 || ar_hs != ar0) begin
      errors++; $display("FAIL comm_disable_block: viol=%0b ar=%0d required 0 0", viol, ar_hs - ar0);
    end
    comm_disable = 0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL comm_disable_release: req_ready=%0b required 1", req_ready); end
    @(negedge clk);
    req_valid = 0;
    get_rsp(0, got, lat, st);
    exp = model_rsp(0, 4'd5, 0, sl_bresp, sl_rresp, sl_rdata);
    checks++;
    if (got !== exp || lat !== 3) begin
      errors++; $display("FAIL comm_disable_rsp: got %h lat=%0d required %h lat=3", got, lat, exp);
    end
    $display("TXN read addr=00000500 tag=%0d data=%h lat=%0d (after enable)", got.tag, got.data, lat);
  endtask

  task automatic test_random();
    rsp_t got, exp;
    int lat, elat, rd, hold, aw0, w0, ar0;
    logic st, w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW/8-1:0] s;
    logic [TGW-1:0] t;
    for (int n = 0; n < 40; n++) begin
      w = 1'($urandom_range(0, 1));
      a = $urandom; d = $urandom; s = 4'($urandom_range(0, 15)); t = 4'($urandom_range(0, 15));
      aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3); ar_delay = $urandom_range(0, 3);
      rd = $urandom_range(0, 10); b_delay = rd; r_delay = rd;
      sl_bresp = 2'($urandom_range(0, 3)); sl_rresp = 2'($urandom_range(0, 3)); sl_rdata = $urandom;
      hold = $urandom_range(0, 2);
      aw0 = aw_hs; w0 = w_hs; ar0 = ar_hs;
      send_req(w, a, d, s, t);
      get_rsp(hold, got, lat, st);
      exp  = model_rsp(w, t, rd, sl_bresp, sl_rresp, sl_rdata);
      elat = model_lat(w, aw_delay, w_delay, ar_delay, rd);
      checks++;
      if (got !== exp || lat !== elat || !st) begin
        errors++; $display("FAIL rand_rsp[%0d]: got %h lat=%0d stable=%0b required %h lat=%0d stable=1",
                           n, got, lat, st, exp, elat);
      end
      checks++;
      if (w ? (sl_awaddr !== a || sl_wdata !== d || sl_wstrb !== s || aw_hs - aw0 !== 1 || w_hs - w0 !== 1)
            : (sl_araddr !== a || ar_hs - ar0 !== 1)) begin
        errors++; $display("FAIL rand_slave[%0d]: addr=%h/%h data=%h strb=%h required addr=%h data=%h strb=%h",
                           n, sl_awaddr, sl_araddr, sl_wdata, sl_wstrb, a, d, s);
      end
      $display("TXN rand %0d %s addr=%h tag=%0d resp=%0d lat=%0d", n, w ? "write" : "read", a, got.tag, got.resp, lat);
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    int b0;
    aw_delay = 0; w_delay = 0; b_delay = 20;
    b0 = b_hs;
    send_req(1, 32'h600, 32'h11112222, 4'hC, 4'd7);
    repeat (2) @(negedge clk);
    checks++;
    if (tx4lbready !== 1'b1) begin errors++; $display("FAIL reset_mid_in_wresp: bready=%0b required 1", tx4lbready); end
    rstnn = 0;
    #1;
    checks++;
    if ({tx4lawvalid, tx4lwvalid, tx4larvalid, tx4lbready, tx4lrready, rsp_valid, req_ready, busy} !== 8'h00) begin
      errors++; $display("FAIL reset_mid_async: got %b required 00000000",
                         {tx4lawvalid, tx4lwvalid, tx4larvalid, tx4lbready, tx4lrready, rsp_valid, req_ready, busy});
    end
    repeat (2) @(negedge clk);
    rstnn = 1;
    b_delay = 0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
    end
    checks++;
    if (seen || req_ready !== 1'b1 || busy !== 1'b0 || b_hs != b0) begin
      errors++; $display("FAIL reset_mid_silent: rsp_seen=%0b req_ready=%0b busy=%0b required 0 1 0",
                         seen, req_ready, busy);
    end
    $display("TXN write addr=00000600 tag=7 aborted by reset");
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_write_aw_delay();
    test_read_hold();
    test_timeout();
    test_comm_disable();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
